// File: rtl/vga_timing_gen_if.sv
// Bundle of the pixel strobe and raster timing outputs of vga_timing_gen.
// The generator drives through the master modport; a display consumer uses the slave modport.
interface vga_timing_gen_if #(
    parameter int CW = 10
) ();
    logic          pix_en;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          video_on;
    logic          line_end;
    logic          frame_end;
    logic          h_sync;
    logic          v_sync;
    logic          de;

    modport master (
        input  pix_en,
        output pixel_x, pixel_y, video_on, line_end, frame_end, h_sync, v_sync, de
    );

    modport slave (
        output pix_en,
        input  pixel_x, pixel_y, video_on, line_end, frame_end, h_sync, v_sync, de
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters advanced by pix_en, display window and coordinates,
// and sync/de delayed by SYNC_DLY pixel ticks to line up with a downstream RGB pipeline.
module vga_timing_gen #(
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter bit V_FLIP   = 1'b0,
    parameter int SYNC_DLY = 1,
    parameter int CW       = 10
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

    logic [CW-1:0] r_h_count;
    logic [CW-1:0] r_v_count;
    sync_t         r_dly [SYNC_DLY];

    logic          w_h_last;
    logic          w_v_last;
    logic          w_h_vis;
    logic          w_v_vis;
    logic          w_video_on;
    logic [CW-1:0] w_h_rel;
    logic [CW-1:0] w_v_rel;
    sync_t         w_raw;

    assign w_h_last   = (r_h_count == CW'(H_TOTAL - 1));
    assign w_v_last   = (r_v_count == CW'(V_TOTAL - 1));
    assign w_h_vis    = (r_h_count >= CW'(H_START)) && (r_h_count < CW'(H_START + H_DISP));
    assign w_v_vis    = (r_v_count >= CW'(V_START)) && (r_v_count < CW'(V_START + V_DISP));
    assign w_video_on = w_h_vis && w_v_vis;
    assign w_h_rel    = r_h_count - CW'(H_START);
    assign w_v_rel    = r_v_count - CW'(V_START);

    assign w_raw.hs = (r_h_count < CW'(H_SYNC)) ? H_POL : ~H_POL;
    assign w_raw.vs = (r_v_count < CW'(V_SYNC)) ? V_POL : ~V_POL;
    assign w_raw.de = w_video_on;

    // NOTE: every state element uses <= so the delay stages shift together on the same tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
            for (int i = 0; i < SYNC_DLY; i++) begin
                r_dly[i] <= SYNC_IDLE;
            end
        end else if (bus.pix_en) begin
            if (w_h_last) begin
                r_h_count <= '0;
                r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
            end else begin
                r_h_count <= r_h_count + 1'b1;
            end
            r_dly[0] <= w_raw;
            for (int i = 1; i < SYNC_DLY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign bus.video_on  = w_video_on;
    assign bus.pixel_x   = w_video_on ? w_h_rel : '0;
    assign bus.pixel_y   = !w_video_on ? '0
                         : V_FLIP     ? CW'(V_DISP - 1) - w_v_rel
                         :              w_v_rel;
    assign bus.line_end  = bus.pix_en && w_h_last;
    assign bus.frame_end = bus.pix_en && w_h_last && w_v_last;
    assign bus.h_sync    = r_dly[SYNC_DLY-1].hs;
    assign bus.v_sync    = r_dly[SYNC_DLY-1].vs;
    assign bus.de        = r_dly[SYNC_DLY-1].de;
endmodule
